// File: rtl/fp_normalize_round.sv
// fp_normalize_round
// Post-add normalize / round-to-nearest-even / pack stage of the single-precision
// ALU. Two register stages (s1 = normalized operand, out = packed result) with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       input handshake (in_ready is combinational from out_ready)
//   in_sign, in_exp           result sign, larger-operand biased exponent
//   in_mant, in_guard         raw 25-bit sum (bit 24 = carry) and guard bit
//   in_sticky                 OR of alignment bits below the guard
//   in_lz_pos, in_lz_zero     leading-zero count from bit 24, all-zero flag
//   out_valid / out_ready     output handshake
//   out_result                packed {sign, exp, frac}
//   out_zero/overflow/underflow  status flags aligned with out_result
module fp_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    input  logic        in_guard,
    input  logic        in_sticky,
    input  logic [4:0]  in_lz_pos,
    input  logic        in_lz_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_overflow,
    output logic        out_underflow
);

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s1_en, s2_en;

    assign s2_en    = !out_valid | out_ready;
    assign s1_en    = !s1_valid | s2_en;
    assign in_ready = s1_en & !rst;

    // ---------------- stage 1: normalize ----------------
    // Shifting {mant, guard} left puts the leading one at bit 25; an illegal
    // count > 24 just yields garbage data, the handshake is unaffected.
    logic [25:0]       norm_ext;
    logic signed [9:0] exp_n_c;

    assign norm_ext = {in_mant, in_guard} << in_lz_pos;
    assign exp_n_c  = $signed({2'b00, in_exp}) + 10'sd1 - $signed({5'b00000, in_lz_pos});

    logic              s1_sign, s1_g, s1_s, s1_zero, s1_uf;
    logic [23:0]       s1_m;
    logic signed [9:0] s1_exp;

    // ---------------- stage 2: round and pack ----------------
    logic              round_up;
    logic [24:0]       mr;
    logic signed [9:0] exp_f;
    logic [22:0]       frac;
    logic [31:0]       nxt_result;
    logic              nxt_zero, nxt_ovf, nxt_uf;

    assign round_up = s1_g & (s1_s | s1_m[0]);
    assign mr       = {1'b0, s1_m} + {24'd0, round_up};

    always_comb begin
        // Rounding carry out of the mantissa renormalizes to 1.0 x 2^(e+1).
        exp_f = mr[24] ? s1_exp + 10'sd1 : s1_exp;
        frac  = mr[24] ? 23'd0 : mr[22:0];

        nxt_result = {s1_sign, exp_f[7:0], frac};
        nxt_zero   = 1'b0;
        nxt_ovf    = 1'b0;
        nxt_uf     = 1'b0;
        if (s1_zero) begin
            nxt_result = 32'h0000_0000;
            nxt_zero   = 1'b1;
        end else if (s1_uf) begin
            // flush to signed zero, no denormals
            nxt_result = {s1_sign, 31'd0};
            nxt_zero   = 1'b1;
            nxt_uf     = 1'b1;
        end else if (exp_f >= 10'sd255) begin
            nxt_result = {s1_sign, 8'hFF, 23'd0};
            nxt_ovf    = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_sign       <= 1'b0;
            s1_m          <= 24'd0;
            s1_g          <= 1'b0;
            s1_s          <= 1'b0;
            s1_exp        <= 10'sd0;
            s1_zero       <= 1'b0;
            s1_uf         <= 1'b0;
            out_valid     <= 1'b0;
            out_result    <= 32'd0;
            out_zero      <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign <= in_sign;
                    s1_m    <= norm_ext[25:2];
                    s1_g    <= norm_ext[1];
                    s1_s    <= norm_ext[0] | in_sticky;
                    s1_exp  <= exp_n_c;
                    s1_zero <= in_lz_zero;
                    s1_uf   <= (exp_n_c <= 10'sd0);
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                // result registers only move when new data arrives, so a held
                // result stays stable until consumed
                if (s1_valid) begin
                    out_result    <= nxt_result;
                    out_zero      <= nxt_zero;
                    out_overflow  <= nxt_ovf;
                    out_underflow <= nxt_uf;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round
// Directed-vector bench for fp_normalize_round: arithmetic cases, flags,
// latency, throughput, backpressure and mid-flight reset.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        in_guard;
    logic        in_sticky;
    logic [4:0]  in_lz_pos;
    logic        in_lz_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_overflow;
    logic        out_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_guard     (in_guard),
        .in_sticky    (in_sticky),
        .in_lz_pos    (in_lz_pos),
        .in_lz_zero   (in_lz_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_zero     (out_zero),
        .out_overflow (out_overflow),
        .out_underflow(out_underflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sg, input logic [7:0] e, input logic [24:0] m,
                         input logic g, input logic s, input logic [4:0] lz, input logic lzz);
        in_sign    = sg;
        in_exp     = e;
        in_mant    = m;
        in_guard   = g;
        in_sticky  = s;
        in_lz_pos  = lz;
        in_lz_zero = lzz;
    endtask

    // Send one transaction into an empty pipeline and wait (bounded) for its
    // result. lat counts clock edges from the accepting edge to the one that
    // presents the result.
    task automatic run_one(output logic [31:0] res, output logic [2:0] flags, output int lat);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        res   = out_result;
        flags = {out_zero, out_overflow, out_underflow};
        step();  // consumed
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(1'b0, 8'd0, 25'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(); step();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", out_result); end
        n_cmp++; if ({out_zero, out_overflow, out_underflow} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags got %b want 000", {out_zero, out_overflow, out_underflow}); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_high got %b want 1", in_ready); end
        step();
    endtask

    task automatic test_one_plus_one();
        logic [31:0] r; logic [2:0] f; int lat;
        drive(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 5'd0, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL one_plus_one got %h want 40000000", r); end
        n_cmp++; if (f !== 3'b000) begin n_fail++; $display("FAIL one_plus_one_flags got %b want 000", f); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL one_plus_one_latency got %0d want 2", lat); end
    endtask

    task automatic test_round_even();
        logic [31:0] r; logic [2:0] f; int lat;
        drive(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 5'd1, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h3F800002) begin n_fail++; $display("FAIL tie_odd got %h want 3f800002", r); end
        drive(1'b0, 8'd127, 25'h0800000, 1'b1, 1'b0, 5'd1, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL tie_even got %h want 3f800000", r); end
        // sticky breaks the tie: 1.0 + just over half an ulp rounds up
        drive(1'b0, 8'd127, 25'h0800000, 1'b1, 1'b1, 5'd1, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h3F800001) begin n_fail++; $display("FAIL above_half got %h want 3f800001", r); end
    endtask

    task automatic test_left_norm();
        logic [31:0] r; logic [2:0] f; int lat;
        drive(1'b0, 8'd130, 25'h0100000, 1'b0, 1'b0, 5'd4, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h3F800000) begin n_fail++; $display("FAIL left_norm got %h want 3f800000", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; logic [2:0] f; int lat;
        drive(1'b1, 8'd100, 25'd0, 1'b0, 1'b0, 5'd24, 1'b1);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h00000000) begin n_fail++; $display("FAIL zero got %h want 00000000", r); end
        n_cmp++; if (f !== 3'b100) begin n_fail++; $display("FAIL zero_flags got %b want 100", f); end
        drive(1'b0, 8'd254, 25'h1FFFFFF, 1'b0, 1'b0, 5'd0, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h7F800000) begin n_fail++; $display("FAIL overflow got %h want 7f800000", r); end
        n_cmp++; if (f !== 3'b010) begin n_fail++; $display("FAIL overflow_flags got %b want 010", f); end
        drive(1'b1, 8'd3, 25'h0000400, 1'b0, 1'b0, 5'd14, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL underflow got %h want 80000000", r); end
        n_cmp++; if (f !== 3'b101) begin n_fail++; $display("FAIL underflow_flags got %b want 101", f); end
        // largest finite: exp 254 with no carry, no rounding
        drive(1'b1, 8'd253, 25'h1FFFFFE, 1'b0, 1'b0, 5'd0, 1'b0);
        run_one(r, f, lat);
        n_cmp++; if (r !== 32'hFF7FFFFF) begin n_fail++; $display("FAIL max_finite got %h want ff7fffff", r); end
        n_cmp++; if (f !== 3'b000) begin n_fail++; $display("FAIL max_finite_flags got %b want 000", f); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[3]; int gcyc[3]; int cnt;
        logic [31:0] exp_r[3];
        exp_r[0] = 32'h40000000; exp_r[1] = 32'h3F800000; exp_r[2] = 32'h3F800002;
        cnt = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid && cnt < 3) begin got[cnt] = out_result; gcyc[cnt] = cyc; cnt++; end
            in_valid = (cyc < 3);
            case (cyc)
                0: drive(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 5'd0, 1'b0);
                1: drive(1'b0, 8'd130, 25'h0100000, 1'b0, 1'b0, 5'd4, 1'b0);
                2: drive(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 5'd1, 1'b0);
                default: ;
            endcase
            if (cyc < 3) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", cyc, in_ready); end
            end
            step();
        end
        n_cmp++; if (cnt !== 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", cnt); end
        for (int i = 0; i < 3; i++) begin
            if (i < cnt) begin
                n_cmp++; if (got[i] !== exp_r[i]) begin n_fail++; $display("FAIL b2b_result %0d got %h want %h", i, got[i], exp_r[i]); end
                n_cmp++; if (gcyc[i] !== i + 2) begin n_fail++; $display("FAIL b2b_cycle %0d got %0d want %0d", i, gcyc[i], i + 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[4]; int cnt;
        logic [31:0] exp_r[3];
        exp_r[0] = 32'h40000000; exp_r[1] = 32'h3F800000; exp_r[2] = 32'h3F800002;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 5'd0, 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_first got %b want 1", in_ready); end
        step();
        drive(1'b0, 8'd130, 25'h0100000, 1'b0, 1'b0, 5'd4, 1'b0);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_second got %b want 1", in_ready); end
        step();
        drive(1'b0, 8'd127, 25'h0800001, 1'b1, 1'b0, 5'd1, 1'b0);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_third got %b want 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_result !== 32'h40000000) begin n_fail++;
                $display("FAIL bp_hold %0d got v=%b %h want v=1 40000000", i, out_valid, out_result); end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_release got %b want 1", in_ready); end
        cnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (out_valid) begin
                if (cnt < 4) got[cnt] = out_result;
                cnt++;
            end
            step();
            in_valid = 1'b0;  // third input taken on the first released edge
        end
        n_cmp++; if (cnt !== 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", cnt); end
        for (int i = 0; i < 3; i++) begin
            if (i < cnt) begin
                n_cmp++; if (got[i] !== exp_r[i]) begin n_fail++; $display("FAIL bp_order %0d got %h want %h", i, got[i], exp_r[i]); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(1'b0, 8'd127, 25'h1000000, 1'b0, 1'b0, 5'd0, 1'b0);
        step();
        drive(1'b0, 8'd130, 25'h0100000, 1'b0, 1'b0, 5'd4, 1'b0);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got %b want 1", out_valid); end
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_in_rst got %b want 0", in_ready); end
        step();
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL mid_out_result got %h want 0", out_result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid) seen++;
            step();
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL mid_stale got %0d want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_one_plus_one();
        test_round_even();
        test_left_norm();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
